// File: rtl/uart_wb_bridge_pkg.sv
// uart_wb_bridge_pkg: command codes, core FSM states and the error-read word.
package uart_wb_bridge_pkg;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ = 8'h02;
  localparam logic [31:0] ERR_READ = 32'hFFFF_FFFF;
  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN, ST_ADDR, ST_WDATA, ST_WB_WR, ST_WB_RD, ST_TX_DATA
  } state_t;
endpackage

// File: rtl/uart_wb_bridge_phy.sv
// uart_wb_bridge_phy: 8N1 UART receiver (glitch and framing checks) and transmitter.
module uart_wb_bridge_phy #(
  parameter int CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready
);
  logic [1:0] r_sync;
  logic r_rx_busy;
  logic [3:0] r_rx_bit;
  logic [15:0] r_rx_cnt;
  logic [7:0] r_rx_sh;
  logic r_tx_busy;
  logic [3:0] r_tx_bit;
  logic [15:0] r_tx_cnt;
  logic [9:0] r_tx_sh;
  logic w_rx, w_half, w_full, w_tx_last;
  assign w_rx = r_sync[1];
  assign w_half = r_rx_bit == 4'd0 && r_rx_cnt == 16'(CLK_DIV / 2 - 1);
  assign w_full = r_rx_bit != 4'd0 && r_rx_cnt == 16'(CLK_DIV - 1);
  assign rx_data = r_rx_sh;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync <= 2'b11;
      r_rx_busy <= 1'b0;
      r_rx_bit <= '0;
      r_rx_cnt <= '0;
      r_rx_sh <= '0;
      rx_valid <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], rx};
      rx_valid <= 1'b0;
      rx_frame_err <= 1'b0;
      if (!r_rx_busy) begin
        r_rx_busy <= !w_rx;
        r_rx_cnt <= '0;
        r_rx_bit <= '0;
      end else if (w_half || w_full) begin
        r_rx_cnt <= '0;
        r_rx_bit <= r_rx_bit + 4'd1;
        if (w_half && w_rx) r_rx_busy <= 1'b0;
        if (w_full && r_rx_bit < 4'd9) r_rx_sh <= {w_rx, r_rx_sh[7:1]};
        if (w_full && r_rx_bit == 4'd9) begin
          r_rx_busy <= 1'b0;
          rx_valid <= w_rx;
          rx_frame_err <= !w_rx;
        end
      end else r_rx_cnt <= r_rx_cnt + 16'd1;
    end
  // Ready in the last stop-bit cycle so queued bytes go out back-to-back.
  assign w_tx_last = r_tx_busy && r_tx_bit == 4'd9 && r_tx_cnt == 16'(CLK_DIV - 1);
  assign tx_ready = !r_tx_busy || w_tx_last;
  assign tx = r_tx_busy ? r_tx_sh[0] : 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_tx_busy <= 1'b0;
      r_tx_bit <= '0;
      r_tx_cnt <= '0;
      r_tx_sh <= '1;
    end else if (tx_valid && tx_ready) begin
      r_tx_busy <= 1'b1;
      r_tx_bit <= '0;
      r_tx_cnt <= '0;
      r_tx_sh <= {1'b1, tx_data, 1'b0};
    end else if (r_tx_busy) begin
      if (r_tx_cnt == 16'(CLK_DIV - 1)) begin
        r_tx_cnt <= '0;
        r_tx_bit <= r_tx_bit + 4'd1;
        r_tx_sh <= {1'b1, r_tx_sh[9:1]};
        r_tx_busy <= r_tx_bit != 4'd9;
      end else r_tx_cnt <= r_tx_cnt + 16'd1;
    end
endmodule

// File: rtl/uart_wb_bridge.sv
// uart_wb_bridge: UART command decoder driving single-word Wishbone classic accesses.
module uart_wb_bridge
  import uart_wb_bridge_pkg::*;
#(
  parameter int CLK_DIV = 868,
  parameter int ADDR_WIDTH = 30,
  parameter int RX_TIMEOUT = 1000000,
  parameter int ACK_TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  uart_rx,
  output logic                  uart_tx,
  output logic [ADDR_WIDTH-1:0] wb_adr,
  output logic [31:0]           wb_dat_w,
  input  logic [31:0]           wb_dat_r,
  output logic [3:0]            wb_sel,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  output logic                  wb_we,
  input  logic                  wb_ack
);
  state_t r_state, w_next;
  logic r_rd;
  logic [7:0] r_len;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [31:0] r_dat;
  logic [1:0] r_bcnt;
  logic [31:0] r_to;
  logic [7:0] w_rx_data;
  logic w_rx_valid, w_rx_err, w_tx_ready, w_tx_valid, w_tx_go;
  logic w_bus, w_rx_st, w_done;
  uart_wb_bridge_phy #(.CLK_DIV(CLK_DIV)) u_phy (
    .clk(clk), .rst_n(rst_n), .rx(uart_rx), .tx(uart_tx),
    .rx_data(w_rx_data), .rx_valid(w_rx_valid), .rx_frame_err(w_rx_err),
    .tx_data(r_dat[31:24]), .tx_valid(w_tx_valid), .tx_ready(w_tx_ready)
  );
  assign w_bus = r_state == ST_WB_WR || r_state == ST_WB_RD;
  assign w_rx_st = r_state == ST_LEN || r_state == ST_ADDR || r_state == ST_WDATA;
  assign w_done = w_bus && (wb_ack || r_to == 32'(ACK_TIMEOUT - 1));
  assign w_tx_valid = r_state == ST_TX_DATA;
  assign w_tx_go = w_tx_valid && w_tx_ready;
  assign wb_cyc = w_bus;
  assign wb_stb = w_bus;
  assign wb_we = r_state == ST_WB_WR;
  assign wb_sel = {4{w_bus}};
  assign wb_adr = r_adr;
  assign wb_dat_w = r_dat;
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_rx_valid && (w_rx_data == CMD_WRITE || w_rx_data == CMD_READ)) w_next = ST_LEN;
      ST_LEN: if (w_rx_valid) w_next = w_rx_data == 8'd0 ? ST_IDLE : ST_ADDR;
      ST_ADDR: if (w_rx_valid && r_bcnt == 2'd3) w_next = r_rd ? ST_WB_RD : ST_WDATA;
      ST_WDATA: if (w_rx_valid && r_bcnt == 2'd3) w_next = ST_WB_WR;
      ST_WB_WR: if (w_done) w_next = r_len == 8'd1 ? ST_IDLE : ST_WDATA;
      ST_WB_RD: if (w_done) w_next = ST_TX_DATA;
      ST_TX_DATA: if (w_tx_go && r_bcnt == 2'd3) w_next = r_len == 8'd0 ? ST_IDLE : ST_WB_RD;
      default: w_next = ST_IDLE;
    endcase
    if (w_rx_st && (w_rx_err || (!w_rx_valid && r_to == 32'(RX_TIMEOUT - 1)))) w_next = ST_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ST_IDLE;
    else r_state <= w_next;
  // r_to times both the inter-byte gap and the outstanding bus cycle.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rd <= 1'b0;
      r_len <= '0;
      r_adr <= '0;
      r_dat <= '0;
      r_bcnt <= '0;
      r_to <= '0;
    end else begin
      r_to <= (w_next != r_state || (w_rx_valid && w_rx_st)) ? '0 : r_to + 32'd1;
      if (r_state == ST_IDLE) r_bcnt <= '0;
      else if (w_tx_go || (w_rx_valid && (r_state == ST_ADDR || r_state == ST_WDATA))) r_bcnt <= r_bcnt + 2'd1;
      if (w_rx_valid && r_state == ST_IDLE) r_rd <= w_rx_data == CMD_READ;
      if (w_rx_valid && r_state == ST_LEN) r_len <= w_rx_data;
      if (w_rx_valid && r_state == ST_ADDR) r_adr <= ADDR_WIDTH'({r_adr, w_rx_data});
      if (w_rx_valid && r_state == ST_WDATA) r_dat <= {r_dat[23:0], w_rx_data};
      if (w_tx_go) r_dat <= {r_dat[23:0], 8'h00};
      if (w_done) begin
        r_len <= r_len - 8'd1;
        r_adr <= r_adr + ADDR_WIDTH'(1);
        if (r_state == ST_WB_RD) r_dat <= wb_ack ? wb_dat_r : ERR_READ;
      end
    end
endmodule
